// File: rtl/h3_hash_serializer_pkg.sv
// h3_pkg: shared types and helpers for the H3 hash serializer.
//   h3_state_t     - serializer FSM states
//   h3_idx_width() - width of the hash-index counter (never below 1 bit)
//   h3_params_t    - parameter array shape at the default configuration
package h3_pkg;

  typedef enum logic {
    IDLE,
    HASHING
  } h3_state_t;

  localparam int unsigned DEF_INPUT_WIDTH = 28;
  localparam int unsigned DEF_HASH_WIDTH  = 8;
  localparam int unsigned DEF_NUM_HASHES  = 3;

  // Entry [h][b] is XORed into hash h when tuple bit b is set.
  typedef logic [DEF_NUM_HASHES-1:0][DEF_INPUT_WIDTH-1:0][DEF_HASH_WIDTH-1:0] h3_params_t;

  function automatic int unsigned h3_idx_width(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/h3_hash_serializer_if.sv
// h3_hash_serializer_if: tuple input handshake plus serial hash output.
//   inp_vld/inp_rdy/inp_data        - tuple handshake (master drives vld/data)
//   outp_vld/hashed_outp/outp_last  - hash stream toward the bloom filter
// Modports: master = upstream/bench side, slave = serializer side.
interface h3_hash_serializer_if
  import h3_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int unsigned HASH_WIDTH  = DEF_HASH_WIDTH
);
  logic                   inp_vld;
  logic                   inp_rdy;
  logic [INPUT_WIDTH-1:0] inp_data;
  logic                   outp_vld;
  logic [HASH_WIDTH-1:0]  hashed_outp;
  logic                   outp_last;

  modport master (
    output inp_vld, inp_data,
    input  inp_rdy, outp_vld, hashed_outp, outp_last
  );

  modport slave (
    input  inp_vld, inp_data,
    output inp_rdy, outp_vld, hashed_outp, outp_last
  );
endinterface

// File: rtl/h3_hash_serializer_hash.sv
// h3_hash: combinational H3 hash of one tuple against one parameter slice.
//   tuple  - input tuple
//   params - [INPUT_WIDTH][HASH_WIDTH] words, params[b] used when tuple[b]=1
//   hash   - XOR of the selected words
module h3_hash #(
  parameter int unsigned INPUT_WIDTH = 28,
  parameter int unsigned HASH_WIDTH  = 8
) (
  input  logic [INPUT_WIDTH-1:0]                 tuple,
  input  logic [INPUT_WIDTH-1:0][HASH_WIDTH-1:0] params,
  output logic [HASH_WIDTH-1:0]                  hash
);
  always_comb begin
    hash = '0;
    for (int unsigned b = 0; b < INPUT_WIDTH; b++) begin
      if (tuple[b]) hash = hash ^ params[b];
    end
  end
endmodule

// File: rtl/h3_hash_serializer.sv
// h3_hash_serializer: accepts one tuple per handshake and emits its
// NUM_HASHES H3 hashes serially, one per clock, gap-free across tuples.
//   clk - clock, rising edge
//   rst - asynchronous active-low reset
//   bus - h3_hash_serializer_if.slave (tuple handshake + hash stream)
// Build option: H3_PIPE_EN adds a register between masking and XOR
// reduction, delaying all outputs by one cycle.
module h3_hash_serializer
  import h3_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int unsigned HASH_WIDTH  = DEF_HASH_WIDTH,
  parameter int unsigned NUM_HASHES  = DEF_NUM_HASHES,
  parameter logic [NUM_HASHES-1:0][INPUT_WIDTH-1:0][HASH_WIDTH-1:0] H3_PARAMS = '0
) (
  input logic                 clk,
  input logic                 rst,
  h3_hash_serializer_if.slave bus
);
  localparam int unsigned   IW   = h3_idx_width(NUM_HASHES);
  localparam logic [IW-1:0] LAST = IW'(NUM_HASHES - 1);

  h3_state_t              state, state_next;
  logic [IW-1:0]          idx, idx_next;
  logic [INPUT_WIDTH-1:0] tuple, tuple_next;
  logic                   at_last, rdy, accept, hashing;

  logic [INPUT_WIDTH-1:0][HASH_WIDTH-1:0] slice;
  logic [HASH_WIDTH-1:0]                  hash;
  logic                                   hash_vld, hash_last;

  assign at_last     = (idx == LAST);
  assign rdy         = (state == IDLE) || ((state == HASHING) && at_last);
  assign bus.inp_rdy = rdy;
  assign accept      = bus.inp_vld && rdy;
  assign hashing     = (state == HASHING);
  assign slice       = H3_PARAMS[idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      tuple <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      tuple <= tuple_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    tuple_next = tuple;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = HASHING;
          idx_next   = '0;
          tuple_next = bus.inp_data;
        end
      end
      HASHING: begin
        if (!at_last) begin
          idx_next = idx + 1'b1;
        end else if (accept) begin
          idx_next   = '0;
          tuple_next = bus.inp_data;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef H3_PIPE_EN
  logic [INPUT_WIDTH-1:0][HASH_WIDTH-1:0] masked_q;
  logic                                   s1_vld, s1_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      masked_q <= '0;
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_vld  <= hashing;
      s1_last <= hashing && at_last;
      if (hashing) begin
        for (int unsigned b = 0; b < INPUT_WIDTH; b++) begin
          masked_q[b] <= tuple[b] ? slice[b] : '0;
        end
      end
    end
  end

  // Words are already masked, so an all-ones tuple turns the hash
  // instance into a plain XOR reduction.
  h3_hash #(.INPUT_WIDTH(INPUT_WIDTH), .HASH_WIDTH(HASH_WIDTH)) u_hash (
    .tuple  ('1),
    .params (masked_q),
    .hash   (hash)
  );
  assign hash_vld  = s1_vld;
  assign hash_last = s1_last;
`else
  h3_hash #(.INPUT_WIDTH(INPUT_WIDTH), .HASH_WIDTH(HASH_WIDTH)) u_hash (
    .tuple  (tuple),
    .params (slice),
    .hash   (hash)
  );
  assign hash_vld  = hashing;
  assign hash_last = hashing && at_last;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.outp_vld    <= 1'b0;
      bus.outp_last   <= 1'b0;
      bus.hashed_outp <= '0;
    end else begin
      bus.outp_vld  <= hash_vld;
      bus.outp_last <= hash_last;
      if (hash_vld) bus.hashed_outp <= hash;
    end
  end
endmodule

// File: tb/tb_h3_hash_serializer.sv
// Bench for h3_hash_serializer: INPUT_WIDTH=4, HASH_WIDTH=8, NUM_HASHES=3.
// Honours H3_PIPE_EN for output latency.
module tb_h3_hash_serializer;
`ifdef H3_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // Packed as {h2, h1, h0}, each hash listed bit3..bit0.
  localparam logic [2:0][3:0][7:0] PARAMS = {
    8'h3C, 8'hF0, 8'h0F, 8'hFF,
    8'h80, 8'h40, 8'h20, 8'h10,
    8'h08, 8'h04, 8'h02, 8'h01
  };

  // Reference table, [hash][bit].
  logic [7:0] ref_tbl [3][4] = '{
    '{8'h01, 8'h02, 8'h04, 8'h08},
    '{8'h10, 8'h20, 8'h40, 8'h80},
    '{8'hFF, 8'h0F, 8'hF0, 8'h3C}
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  h3_hash_serializer_if #(.INPUT_WIDTH(4), .HASH_WIDTH(8)) bus ();

  h3_hash_serializer #(
    .INPUT_WIDTH (4),
    .HASH_WIDTH  (8),
    .NUM_HASHES  (3),
    .H3_PARAMS   (PARAMS)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] h;
    logic       last;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   vld_cnt = 0;

  function automatic logic [7:0] model(input logic [3:0] t, input int h);
    logic [7:0] r = 8'h00;
    for (int b = 0; b < 4; b++) if (t[b]) r = r ^ ref_tbl[h][b];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_tuple(input logic [3:0] t);
    for (int h = 0; h < 3; h++) sbq.push_back('{h: model(t, h), last: (h == 2)});
  endtask

  // Scoreboard: every valid output cycle must match the next expected hash.
  always @(negedge clk) begin
    if (rst_n && bus.outp_vld) begin
      vld_cnt++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_out: observed=%0h expected=none", bus.hashed_outp);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("hash", {24'b0, bus.hashed_outp}, {24'b0, e.h});
        chk("last", {31'b0, bus.outp_last}, {31'b0, e.last});
      end
    end
  end

  task automatic run_single(input logic [3:0] t);
    vld_cnt = 0;
    @(negedge clk);
    chk("single_rdy", {31'b0, bus.inp_rdy}, 32'd1);
    bus.inp_vld  = 1'b1;
    bus.inp_data = t;
    push_tuple(t);
    @(posedge clk);
    #1;
    bus.inp_vld  = 1'b0;
    bus.inp_data = 4'($urandom);
    for (int k = 0; k <= LAT + 3; k++) begin
      @(negedge clk);
      chk("single_vld", {31'b0, bus.outp_vld}, {31'b0, (k >= LAT && k < LAT + 3)});
    end
    chk("single_q_empty", sbq.size(), 32'd0);
    chk("single_vld_cnt", vld_cnt, 32'd3);
    chk("single_hold", {24'b0, bus.hashed_outp}, {24'b0, model(t, 2)});
  endtask

  initial begin
    bus.inp_vld  = 1'b0;
    bus.inp_data = 4'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld",  {31'b0, bus.outp_vld},    32'd0);
    chk("rst_last", {31'b0, bus.outp_last},   32'd0);
    chk("rst_hash", {24'b0, bus.hashed_outp}, 32'd0);
    chk("rst_rdy",  {31'b0, bus.inp_rdy},     32'd1);
    rst_n = 1'b1;

    // Single tuples, including the all-zero tuple
    run_single(4'b0101);
    run_single(4'b0000);

    // Back-to-back: second tuple accepted on the last hash of the first
    vld_cnt = 0;
    @(negedge clk);
    bus.inp_vld  = 1'b1;
    bus.inp_data = 4'b0101;
    push_tuple(4'b0101);
    @(posedge clk);
    for (int k = 0; k <= LAT + 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.inp_data = 4'b1111;
        push_tuple(4'b1111);
      end
      if (k == 3) begin
        bus.inp_vld  = 1'b0;
        bus.inp_data = 4'($urandom);
      end
      chk("b2b_rdy", {31'b0, bus.inp_rdy}, {31'b0, (k < 6) ? (k % 3 == 2) : 1'b1});
      chk("b2b_vld", {31'b0, bus.outp_vld}, {31'b0, (k >= LAT && k < LAT + 6)});
    end
    chk("b2b_q_empty", sbq.size(), 32'd0);
    chk("b2b_vld_cnt", vld_cnt, 32'd6);

    // Reset mid-group: only the first hash of 1111 may appear
    vld_cnt = 0;
    @(negedge clk);
    bus.inp_vld  = 1'b1;
    bus.inp_data = 4'b1111;
    sbq.push_back('{h: model(4'b1111, 0), last: 1'b0});
    @(posedge clk);
    #1;
    bus.inp_vld = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld",  {31'b0, bus.outp_vld},  32'd0);
    chk("midrst_last", {31'b0, bus.outp_last}, 32'd0);
    chk("midrst_rdy",  {31'b0, bus.inp_rdy},   32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_vld", {31'b0, bus.outp_vld}, 32'd0);
    end
    chk("post_rst_rdy", {31'b0, bus.inp_rdy}, 32'd1);
    chk("post_rst_q_empty", sbq.size(), 32'd0);
    chk("post_rst_vld_cnt", vld_cnt, 32'd1);

    // Recovery after reset
    run_single(4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/h3_hash_serializer.md
# h3_hash_serializer

Upstream feeder for `bloom_filter`: accepts one input tuple per handshake and emits its NUM_HASHES H3 hashes serially, one per clock, on the `inp_vld`/`hashed_inp` port of the filter. Each H3 hash is the XOR of the parameter words selected by the set bits of the tuple. Back-to-back tuples produce a gap-free hash stream with no idle cycles.

## Interface
Parameters:
- INPUT_WIDTH, 28, tuple width in bits.
- HASH_WIDTH, 8, hash width; matches the filter's `hashed_inp` width.
- NUM_HASHES, 3, hashes per tuple, ≥1.
- H3_PARAMS, all zeros, packed `[NUM_HASHES][INPUT_WIDTH][HASH_WIDTH]`; entry `[h][b]` is the word XORed into hash h when tuple bit b = 1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- inp_vld  in  1  tuple valid.
- inp_rdy  out  1  block can accept a tuple this cycle.
- inp_data  in  INPUT_WIDTH  tuple.
- outp_vld  out  1  `hashed_outp` valid; connects to filter `inp_vld`.
- hashed_outp  out  HASH_WIDTH  current hash; connects to filter `hashed_inp`.
- outp_last  out  1  marks hash index NUM_HASHES-1 of a group.

## Operation
- FSM has two states, IDLE and HASHING. The index counter `idx` is $clog2(NUM_HASHES) bits wide (minimum 1). The tuple register holds INPUT_WIDTH bits.
- `inp_rdy` = (state==IDLE) || (state==HASHING && idx==NUM_HASHES-1). It is combinational from registered state only and never depends on `inp_vld`.
- Accept happens on an edge where `inp_vld && inp_rdy`. On accept: latch `inp_data`, go to HASHING, set idx=0.
- In HASHING, each edge registers `hashed_outp` = H3(tuple, idx), sets `outp_vld`=1, and sets `outp_last`=(idx==NUM_HASHES-1).
  - If idx<NUM_HASHES-1: idx increments.
  - Else, with accept: reload the tuple and set idx=0.
  - Else, without accept: go to IDLE.
- In IDLE, each edge clears `outp_vld` and `outp_last`. `hashed_outp` holds its last value.
- H3(t,h) = XOR over b of (t[b] ? H3_PARAMS[h][b] : 0). This is a pure XOR reduction with no arithmetic carries. All-zero tuple gives 0.
- The filter applies no backpressure. Once a group starts it always completes NUM_HASHES cycles.
- NUM_HASHES==1: idx is a constant 0 and `inp_rdy` is always 1 after reset.

## Timing
- Reset values: state IDLE, idx 0, `outp_vld` 0, `outp_last` 0, `hashed_outp` 0, tuple register 0. `inp_rdy` reads 1 while in reset.
- Latency: for a tuple accepted at edge n, hash j is valid after edge n+1+j for j=0..NUM_HASHES-1. `outp_vld` is high for exactly NUM_HASHES consecutive cycles per tuple.
- Throughput: one tuple per NUM_HASHES cycles. A new accept coinciding with the last hash causes no bubble.
- `inp_data` is sampled only on the accept edge. Changes at any other time have no effect.
- Reset asserted mid-group aborts the group immediately (asynchronously). No remaining hashes are emitted, and after release the block is in IDLE.

## Configuration
- `H3_PIPE_EN` defined:
  - Adds a register stage between the per-bit masking (AND of tuple bit with parameter word) and the XOR reduction.
  - Every output, including `outp_vld` and `outp_last`, is delayed by exactly one extra cycle, so hash j is valid after edge n+2+j.
  - `inp_rdy` timing is unchanged and throughput is unchanged.
  - Reset clears the pipeline register's valid bit.
- `H3_PIPE_EN` undefined: masking and XOR are single-cycle combinational logic feeding the `hashed_outp` register, giving the latency stated in Timing.

## Structure
- Package `h3_pkg` holds:
  - the FSM state enum `h3_state_t` {IDLE, HASHING};
  - function `h3_idx_width(n)` returning max(1, $clog2(n));
  - a typedef for the parameter array shape.
- Sub-module `h3_hash`: combinational, parameters INPUT_WIDTH/HASH_WIDTH, inputs tuple + one hash's `[INPUT_WIDTH][HASH_WIDTH]` parameter slice, output one hash. The top level muxes the slice by idx into a single instance.

## Test plan
Common setup: INPUT_WIDTH=4, HASH_WIDTH=8, NUM_HASHES=3. Params per hash, words listed for bit0..bit3:
- h0 = {01,02,04,08}
- h1 = {10,20,40,80}
- h2 = {FF,0F,F0,3C}

Scenarios:
- Reset: hold rst=0 for 2 cycles -> `outp_vld`=0, `outp_last`=0, `hashed_outp`=00, `inp_rdy`=1.
- Single tuple 4'b0101 accepted at edge n -> after edges n+1/n+2/n+3, `hashed_outp`=05/50/0F with `outp_last`=0/0/1; `outp_vld` falls after edge n+4.
- Back-to-back: 4'b0101 then 4'b1111 with `inp_vld` held high -> contiguous stream 05,50,0F,0F,F0,3C, six `outp_vld` cycles, `inp_rdy` high only on idx 2.
- Zero tuple 4'b0000 -> three valid hashes, all 00.
- Reset mid-group: assert rst after the first hash of 4'b1111 -> `outp_vld`=0 immediately; after release no F0/3C appear and `inp_rdy`=1.
- With `H3_PIPE_EN`: repeat the single-tuple scenario -> same values, each one edge later (n+2..n+4).
